// File: rtl/cacheline_burst_adaptor.sv
// Splits a cache line read/write into a fixed burst of BURST_W-bit beats on the
// memory side and returns a single line-wide completion to the cache.
module cacheline_burst_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned BEATS   = LINE_W / BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int unsigned      CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic [LINE_W-1:0] rline_q, rline_d;

    // Byte offset within the line is dropped; bursts always start line-aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_i[4:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        unique case (state_q)
            IDLE: begin
                // Write has priority if the cache raises both requests.
                if (write_i) begin
                    wline_d = line_i;
                    addr_d  = {address_i[31:5], 5'b0};
                    cnt_d   = '0;
                    state_d = WR;
                end else if (read_i) begin
                    addr_d  = {address_i[31:5], 5'b0};
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                if (resp_i) begin
                    rline_d[cnt_q*BURST_W +: BURST_W] = burst_i;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            WR: begin
                if (resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read_o    = (state_q == RD);
    assign write_o   = (state_q == WR);
    assign resp_o    = (state_q == DONE);
    assign address_o = addr_q;
    assign line_o    = rline_q;
    assign burst_o   = wline_q[cnt_q*BURST_W +: BURST_W];

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed self-checking bench for cacheline_burst_adaptor.
module tb_cacheline_burst_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int unsigned total = 0;
    int unsigned bad   = 0;

    cacheline_burst_adaptor #(
        .LINE_W (256),
        .BURST_W(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0]  words [4];
    logic [63:0]  rd_a  [4];
    logic [63:0]  rd_b  [4];
    logic [6:0]   pat;
    logic [255:0] line_a;
    logic [255:0] line_b;
    int unsigned  beats;

    initial begin
        words[0] = 64'hA0A0_0000_0000_0001;
        words[1] = 64'hB1B1_0000_0000_0002;
        words[2] = 64'hC2C2_0000_0000_0003;
        words[3] = 64'hD3D3_0000_0000_0004;
        rd_a[0]  = 64'h1111_1111_1111_1111;
        rd_a[1]  = 64'h2222_2222_2222_2222;
        rd_a[2]  = 64'h3333_3333_3333_3333;
        rd_a[3]  = 64'h4444_4444_4444_4444;
        rd_b[0]  = 64'h0123_4567_89AB_CDEF;
        rd_b[1]  = 64'hFEDC_BA98_7654_3210;
        rd_b[2]  = 64'h5555_AAAA_5555_AAAA;
        rd_b[3]  = 64'h0F0F_F0F0_0F0F_F0F0;
        line_a   = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_b   = {64'h0F0F_F0F0_0F0F_F0F0, 64'h5555_AAAA_5555_AAAA,
                    64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        pat      = 7'b1011001;

        rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick();
        tick();
        check("rst_read_o",  256'(read_o),  256'd0);
        check("rst_write_o", 256'(write_o), 256'd0);
        check("rst_resp_o",  256'(resp_o),  256'd0);
        check("rst_line_o",  line_o,        256'd0);
        rst = 1'b1;
        tick();

        // Read, no gaps
        read_i = 1'b1; address_i = 32'h0000_1234; resp_i = 1'b1; burst_i = 64'hDEAD;
        tick();
        check("rd_read_o",   256'(read_o),    256'd1);
        check("rd_addr_o",   256'(address_o), 256'h0000_1220);
        check("rd_line_pre", line_o,          256'd0);
        for (int i = 0; i < 4; i++) begin
            burst_i = rd_a[i];
            tick();
            check("rd_resp_timing", 256'(resp_o), (i == 3) ? 256'd1 : 256'd0);
        end
        check("rd_read_o_low", 256'(read_o), 256'd0);
        check("rd_line_o",     line_o,       line_a);
        read_i = 1'b0; resp_i = 1'b0;
        tick();
        check("rd_resp_once", 256'(resp_o), 256'd0);
        tick();

        // Write with gaps, operands disturbed mid-burst
        write_i = 1'b1; address_i = 32'h0000_ABCD;
        line_i = {words[3], words[2], words[1], words[0]};
        tick();
        check("wr_write_o", 256'(write_o), 256'd1);
        check("wr_burst0",  256'(burst_o), 256'(words[0]));
        beats = 0;
        for (int k = 0; k < 7; k++) begin
            resp_i = pat[k];
            if (k == 2) begin
                line_i = '1;
                address_i = 32'hFFFF_FFFF;
            end
            tick();
            if (pat[k]) beats++;
            if (beats < 4) begin
                check("wr_write_hold", 256'(write_o),   256'd1);
                check("wr_no_resp",    256'(resp_o),    256'd0);
                check("wr_burst_o",    256'(burst_o),   256'(words[beats]));
                check("wr_addr_hold",  256'(address_o), 256'h0000_ABC0);
            end else begin
                check("wr_resp_o",     256'(resp_o),  256'd1);
                check("wr_write_done", 256'(write_o), 256'd0);
            end
        end
        write_i = 1'b0; resp_i = 1'b0;
        tick();
        check("wr_resp_once",  256'(resp_o), 256'd0);
        check("wr_line_o_kept", line_o,      line_a);

        // Both requests: write wins
        read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0040; line_i = '0;
        tick();
        check("both_write_o", 256'(write_o), 256'd1);
        resp_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("both_no_read", 256'(read_o), 256'd0);
            tick();
        end
        check("both_resp_o",  256'(resp_o), 256'd1);
        check("both_no_read_done", 256'(read_o), 256'd0);
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        tick();

        // Back-to-back: read then write held through DONE
        read_i = 1'b1; address_i = 32'h0000_2010;
        tick();
        check("b2b_rd_addr", 256'(address_o), 256'h0000_2000);
        resp_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            burst_i = rd_b[i];
            tick();
        end
        check("b2b_rd_resp", 256'(resp_o), 256'd1);
        check("b2b_rd_line", line_o,        line_b);
        read_i = 1'b0; write_i = 1'b1; resp_i = 1'b0; address_i = 32'h0000_3000;
        line_i = {words[0], words[1], words[2], words[3]};
        tick();
        check("b2b_done_resp", 256'(resp_o),  256'd0);
        check("b2b_done_wr",   256'(write_o), 256'd0);
        check("b2b_done_rd",   256'(read_o),  256'd0);
        tick();
        check("b2b_wr_start", 256'(write_o),   256'd1);
        check("b2b_wr_addr",  256'(address_o), 256'h0000_3000);
        check("b2b_wr_beat0", 256'(burst_o),   256'(words[3]));
        resp_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("b2b_wr_resp", 256'(resp_o), 256'd1);
        write_i = 1'b0; resp_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_quiet", 256'({resp_o, read_o, write_o}), 256'd0);
        end

        // Asynchronous reset mid-read after two beats
        read_i = 1'b1; address_i = 32'h0000_5000;
        tick();
        resp_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            burst_i = rd_a[i];
            tick();
        end
        check("mid_rd_active", 256'(read_o), 256'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_read_o", 256'(read_o),    256'd0);
        check("arst_resp_o", 256'(resp_o),    256'd0);
        check("arst_addr_o", 256'(address_o), 256'd0);
        check("arst_burst",  256'(burst_o),   256'd0);
        check("arst_line_o", line_o,          256'd0);
        read_i = 1'b0; resp_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_idle", 256'({resp_o, read_o, write_o}), 256'd0);
        read_i = 1'b1; address_i = 32'h0000_6000;
        tick();
        resp_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            burst_i = rd_b[i];
            tick();
        end
        check("post_rst_resp", 256'(resp_o), 256'd1);
        check("post_rst_line", line_o,       line_b);
        read_i = 1'b0; resp_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cacheline_burst_adaptor.md
# cacheline_burst_adaptor

Sits between the cache's physical-memory port and the burst-oriented main-memory model. Converts one 256-bit line read or write into a fixed burst of four 64-bit beats, and returns a single line-wide response to the cache. Line-side signals mirror the cache's `pmem_*` port one-to-one. The memory side is the 64-bit burst bus.

## Interface
Parameters:
- `LINE_W`, 256, line width in bits (must equal `BURST_W * BEATS`)
- `BURST_W`, 64, burst beat width in bits
- `BEATS`, 4, beats per line (derived as `LINE_W/BURST_W`; not to be overridden independently)

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset; asynchronous, active-low (asserted when 0)
- `line_i`  in  LINE_W  write line from cache (`pmem_wdata`)
- `line_o`  out  LINE_W  read line to cache (`pmem_rdata`)
- `address_i`  in  32  line address from cache (`pmem_address`)
- `read_i`  in  1  line read request (`pmem_read`)
- `write_i`  in  1  line write request (`pmem_write`)
- `resp_o`  out  1  line transaction complete (`pmem_resp`)
- `burst_i`  in  BURST_W  read beat from memory
- `burst_o`  out  BURST_W  write beat to memory
- `address_o`  out  32  burst base address, always 32-byte aligned
- `read_o`  out  1  burst read request
- `write_o`  out  1  burst write request
- `resp_i`  in  1  memory beat handshake; one beat transferred per cycle in which it is high

## Operation
FSM states: `IDLE`, `RD`, `WR`, `DONE`. There is also a 2-bit beat counter `cnt`.

- **IDLE**
  - Samples `read_i`/`write_i`.
  - On `write_i`: latch `line_i`, latch `address_o = {address_i[31:5],5'b0}`, set `cnt=0`, go to `WR`.
  - On `read_i` only: latch the address the same way, set `cnt=0`, go to `RD`.
  - If both are high (illegal): write wins.
  - `resp_i` is ignored in `IDLE`.
- **RD**
  - `read_o=1` for the whole state.
  - Each cycle with `resp_i=1`: store `burst_i` into `line_o[cnt*64 +: 64]` and increment `cnt`.
  - On the beat with `cnt==3`: go to `DONE`.
  - Cycles with `resp_i=0` are gaps: no update.
- **WR**
  - `write_o=1` for the whole state.
  - `burst_o = latched_line[cnt*64 +: 64]`.
  - Each `resp_i=1` counts as one beat accepted: increment `cnt`.
  - After the 4th beat: go to `DONE`.
- **DONE**
  - `resp_o=1` for exactly one cycle, then go to `IDLE` unconditionally.
  - Requests still high during `DONE` are ignored. The cache drops its request on seeing `resp_o`.
- Beat order: ascending. Beat 0 is bits 63:0; beat 3 is bits 255:192.
- `line_o`:
  - Updated only by `RD` beats.
  - Holds its value after `DONE` until the next read's beats overwrite it.
  - Valid in the `resp_o` cycle.
- `address_o`, `burst_o`, and the latched line are stable for the entire burst. Changes on `address_i`/`line_i` mid-burst have no effect.
- Line side must hold `read_i`/`write_i` and their operands until `resp_o`. The adaptor does not depend on that, because operands are latched at accept.

## Timing
- Reset (`rst=0`, asynchronous): state `IDLE`, `cnt=0`. Outputs `read_o`, `write_o`, `resp_o`, `address_o`, `burst_o`, `line_o` are all 0 immediately.
- Reset mid-burst: the burst is abandoned with no `resp_o`. Memory is assumed reset simultaneously.
- Request accepted at edge t (sampled in `IDLE`) → `read_o`/`write_o` high from t+1.
- 4th `resp_i` beat at edge u → `read_o`/`write_o` low and `resp_o` high from u+1, for one cycle. State is `IDLE` again from u+2.
- Minimum latency, request to `resp_o`: 6 cycles (1 accept, 4 back-to-back beats, 1 `DONE`). Each gap cycle adds one.
- Back-to-back: a new request can be accepted at the earliest in the cycle after `resp_o` (u+2).
- `resp_o` never coincides with `read_o` or `write_o`.

## Test plan
- **Reset:** assert `rst=0` mid-`RD` after 2 beats → all outputs 0 immediately. After release, `IDLE`; a new read completes normally with no stale beats in `line_o`.
- **Read, no gaps:** `read_i`, `address_i=0x0000_1234`; memory returns beats `0x11..11`, `0x22..22`, `0x33..33`, `0x44..44` on consecutive cycles.
  - `address_o=0x0000_1220`.
  - `resp_o` high 6 cycles after accept for exactly 1 cycle.
  - `line_o={0x44..44,0x33..33,0x22..22,0x11..11}`.
- **Write, gapped:** `write_i`, `line_i` = 4 distinct 64-bit words; `resp_i` pattern 1,0,0,1,1,0,1.
  - `burst_o` steps through words 0..3 only on `resp_i` cycles.
  - `write_o` holds through the gaps.
  - `resp_o` comes one cycle after the last beat.
- **Operand stability:** change `address_i`/`line_i` during a write burst → `address_o`/`burst_o` unchanged.
- **Both requests:** `read_i=write_i=1` → write burst performed, `read_o` never asserted.
- **Back-to-back:** read then write with the request held through `DONE` → second burst starts at u+2, no duplicate transaction, no spurious `resp_o`.
